// File: rtl/ccip_arb_pkg.sv
// Shared widths, index/credit types and the mdata tag helper for the
// CCI-P read/write arbiter.
package ccip_arb_pkg;

    localparam int CL_ADDR_W = 42;
    localparam int CL_DATA_W = 512;
    localparam int MDATA_W   = 16;
    localparam int TAG_W     = 4;

    typedef logic [TAG_W-1:0] t_req_idx;
    typedef logic [7:0]       t_credit;

    // The requester index sits in the low tag bits; the rest of mdata stays zero.
    function automatic logic [MDATA_W-1:0] make_mdata(input t_req_idx idx);
        return {{(MDATA_W-TAG_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/ccip_rr_arbiter.sv
// Round-robin picker: selects the first eligible requester at or after the
// pointer, wrapping around, and moves the pointer past the winner on advance.
module ccip_rr_arbiter
    import ccip_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output t_req_idx           o_grant_idx,
    output logic               o_grant_valid
);

    t_req_idx r_ptr;
    t_req_idx w_idx;
    logic     w_found;
    int       w_dist;
    int       w_best;

    // Smallest wrapped distance from the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_dist  = 0;
        w_best  = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr)) : (j + NUM_REQ - int'(r_ptr));
            if (i_eligible[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_idx   = t_req_idx'(j);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            o_grant[j] = w_found && (w_idx == t_req_idx'(j));
        end
    end

    assign o_grant_idx   = w_idx;
    assign o_grant_valid = w_found;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (w_idx == t_req_idx'(NUM_REQ-1)) ? '0 : (w_idx + t_req_idx'(1));
        end
    end

endmodule

// File: rtl/ccip_rw_arbiter.sv
// Shares one CCI-P port between NUM_REQ engines: independent round-robin on
// c0 (read) and c1 (write), per-requester credits, and tag-based response routing.
module ccip_rw_arbiter
    import ccip_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                               i_clk,
    input  logic                               i_reset,

    input  logic [NUM_REQ-1:0]                 i_req_rd_valid,
    input  logic [NUM_REQ-1:0][CL_ADDR_W-1:0]  i_req_rd_addr,
    output logic [NUM_REQ-1:0]                 o_req_rd_ready,
    input  logic [NUM_REQ-1:0]                 i_req_wr_valid,
    input  logic [NUM_REQ-1:0][CL_ADDR_W-1:0]  i_req_wr_addr,
    input  logic [NUM_REQ-1:0][CL_DATA_W-1:0]  i_req_wr_data,
    output logic [NUM_REQ-1:0]                 o_req_wr_ready,

    output logic [NUM_REQ-1:0]                 o_rsp_rd_valid,
    output logic [CL_DATA_W-1:0]               o_rsp_rd_data,
    output logic [NUM_REQ-1:0]                 o_rsp_wr_valid,

    output logic                               o_c0_tx_valid,
    output logic [CL_ADDR_W-1:0]               o_c0_tx_addr,
    output logic [MDATA_W-1:0]                 o_c0_tx_mdata,
    output logic                               o_c1_tx_valid,
    output logic [CL_ADDR_W-1:0]               o_c1_tx_addr,
    output logic [CL_DATA_W-1:0]               o_c1_tx_data,
    output logic [MDATA_W-1:0]                 o_c1_tx_mdata,
    output logic                               o_c1_tx_sop,
    input  logic                               i_c0_tx_alm_full,
    input  logic                               i_c1_tx_alm_full,

    input  logic                               i_c0_rx_rsp_valid,
    input  logic [MDATA_W-1:0]                 i_c0_rx_mdata,
    input  logic [CL_DATA_W-1:0]               i_c0_rx_data,
    input  logic                               i_c1_rx_rsp_valid,
    input  logic [MDATA_W-1:0]                 i_c1_rx_mdata,

    output logic                               o_idle,
    output logic                               o_tag_err
);

    t_credit r_rd_credit [NUM_REQ];
    t_credit r_wr_credit [NUM_REQ];

    logic                 r_c0_tx_valid;
    logic [CL_ADDR_W-1:0] r_c0_tx_addr;
    logic [MDATA_W-1:0]   r_c0_tx_mdata;
    logic                 r_c1_tx_valid;
    logic [CL_ADDR_W-1:0] r_c1_tx_addr;
    logic [CL_DATA_W-1:0] r_c1_tx_data;
    logic [MDATA_W-1:0]   r_c1_tx_mdata;
    logic [NUM_REQ-1:0]   r_rsp_rd_valid;
    logic [CL_DATA_W-1:0] r_rsp_rd_data;
    logic [NUM_REQ-1:0]   r_rsp_wr_valid;
    logic                 r_tag_err;

    logic [NUM_REQ-1:0]   w_rd_elig;
    logic [NUM_REQ-1:0]   w_wr_elig;
    logic [NUM_REQ-1:0]   w_rd_grant;
    logic [NUM_REQ-1:0]   w_wr_grant;
    t_req_idx             w_rd_idx;
    t_req_idx             w_wr_idx;
    logic                 w_rd_found;
    logic                 w_wr_found;
    logic                 w_rd_fire;
    logic                 w_wr_fire;
    logic [CL_ADDR_W-1:0] w_rd_addr_sel;
    logic [CL_ADDR_W-1:0] w_wr_addr_sel;
    logic [CL_DATA_W-1:0] w_wr_data_sel;
    t_req_idx             w_c0_tag;
    t_req_idx             w_c1_tag;
    logic [NUM_REQ-1:0]   w_c0_hit;
    logic [NUM_REQ-1:0]   w_c1_hit;
    logic                 w_c0_bad;
    logic                 w_c1_bad;
    logic                 w_credits_zero;
    logic                 w_unused_mdata;

    // Eligibility is suppressed during reset so no handshake can slip through.
    always_comb begin
        w_rd_elig = '0;
        w_wr_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rd_elig[i] = !i_reset && i_req_rd_valid[i] && (r_rd_credit[i] < t_credit'(MAX_OUTSTANDING));
            w_wr_elig[i] = !i_reset && i_req_wr_valid[i] && (r_wr_credit[i] < t_credit'(MAX_OUTSTANDING));
        end
    end

    ccip_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_eligible    (w_rd_elig),
        .i_advance     (w_rd_fire),
        .o_grant       (w_rd_grant),
        .o_grant_idx   (w_rd_idx),
        .o_grant_valid (w_rd_found)
    );

    ccip_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_eligible    (w_wr_elig),
        .i_advance     (w_wr_fire),
        .o_grant       (w_wr_grant),
        .o_grant_idx   (w_wr_idx),
        .o_grant_valid (w_wr_found)
    );

    assign w_rd_fire      = w_rd_found && !i_c0_tx_alm_full;
    assign w_wr_fire      = w_wr_found && !i_c1_tx_alm_full;
    assign o_req_rd_ready = w_rd_grant & {NUM_REQ{!i_c0_tx_alm_full}};
    assign o_req_wr_ready = w_wr_grant & {NUM_REQ{!i_c1_tx_alm_full}};

    always_comb begin
        w_rd_addr_sel = '0;
        w_wr_addr_sel = '0;
        w_wr_data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_rd_idx == t_req_idx'(i)) w_rd_addr_sel = i_req_rd_addr[i];
            if (w_wr_idx == t_req_idx'(i)) begin
                w_wr_addr_sel = i_req_wr_addr[i];
                w_wr_data_sel = i_req_wr_data[i];
            end
        end
    end

    // A response only routes if its tag names a real requester holding a credit.
    assign w_c0_tag = i_c0_rx_mdata[TAG_W-1:0];
    assign w_c1_tag = i_c1_rx_mdata[TAG_W-1:0];

    always_comb begin
        w_c0_hit = '0;
        w_c1_hit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_c0_hit[i] = i_c0_rx_rsp_valid && (w_c0_tag == t_req_idx'(i)) && (r_rd_credit[i] != '0);
            w_c1_hit[i] = i_c1_rx_rsp_valid && (w_c1_tag == t_req_idx'(i)) && (r_wr_credit[i] != '0);
        end
    end

    assign w_c0_bad       = i_c0_rx_rsp_valid && !(|w_c0_hit);
    assign w_c1_bad       = i_c1_rx_rsp_valid && !(|w_c1_hit);
    assign w_unused_mdata = ^{i_c0_rx_mdata[MDATA_W-1:TAG_W], i_c1_rx_mdata[MDATA_W-1:TAG_W]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_rd_credit[i] <= '0;
                r_wr_credit[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({o_req_rd_ready[i], w_c0_hit[i]})
                    2'b10:   r_rd_credit[i] <= r_rd_credit[i] + t_credit'(1);
                    2'b01:   r_rd_credit[i] <= r_rd_credit[i] - t_credit'(1);
                    default: r_rd_credit[i] <= r_rd_credit[i];
                endcase
                case ({o_req_wr_ready[i], w_c1_hit[i]})
                    2'b10:   r_wr_credit[i] <= r_wr_credit[i] + t_credit'(1);
                    2'b01:   r_wr_credit[i] <= r_wr_credit[i] - t_credit'(1);
                    default: r_wr_credit[i] <= r_wr_credit[i];
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_c0_tx_valid  <= 1'b0;
            r_c0_tx_addr   <= '0;
            r_c0_tx_mdata  <= '0;
            r_c1_tx_valid  <= 1'b0;
            r_c1_tx_addr   <= '0;
            r_c1_tx_data   <= '0;
            r_c1_tx_mdata  <= '0;
            r_rsp_rd_valid <= '0;
            r_rsp_rd_data  <= '0;
            r_rsp_wr_valid <= '0;
            r_tag_err      <= 1'b0;
        end else begin
            r_c0_tx_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_c0_tx_addr  <= w_rd_addr_sel;
                r_c0_tx_mdata <= make_mdata(w_rd_idx);
            end
            r_c1_tx_valid <= w_wr_fire;
            if (w_wr_fire) begin
                r_c1_tx_addr  <= w_wr_addr_sel;
                r_c1_tx_data  <= w_wr_data_sel;
                r_c1_tx_mdata <= make_mdata(w_wr_idx);
            end
            r_rsp_rd_valid <= w_c0_hit;
            r_rsp_wr_valid <= w_c1_hit;
            if (i_c0_rx_rsp_valid) begin
                r_rsp_rd_data <= i_c0_rx_data;
            end
            if (w_c0_bad || w_c1_bad) begin
                r_tag_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_credits_zero = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((r_rd_credit[i] != '0) || (r_wr_credit[i] != '0)) w_credits_zero = 1'b0;
        end
    end

    assign o_c0_tx_valid  = r_c0_tx_valid;
    assign o_c0_tx_addr   = r_c0_tx_addr;
    assign o_c0_tx_mdata  = r_c0_tx_mdata;
    assign o_c1_tx_valid  = r_c1_tx_valid;
    assign o_c1_tx_addr   = r_c1_tx_addr;
    assign o_c1_tx_data   = r_c1_tx_data;
    assign o_c1_tx_mdata  = r_c1_tx_mdata;
    assign o_c1_tx_sop    = 1'b1;
    assign o_rsp_rd_valid = r_rsp_rd_valid;
    assign o_rsp_rd_data  = r_rsp_rd_data;
    assign o_rsp_wr_valid = r_rsp_wr_valid;
    assign o_tag_err      = r_tag_err;
    assign o_idle         = w_credits_zero && !r_c0_tx_valid && !r_c1_tx_valid;

endmodule
